read_arbiter: RTL and testbench

- Shares S slave read ports among M master read ports of the AXI-lite interconnect. Covers the AR and R channels; it is the read-side counterpart of the write-path arbitration.
- AR channel: round-robin grant per master, address-decoded slave select, and recording of the target slave in a per-master in-order queue.
- R channel: replays those queues so each master's read bursts return in issue order. Only one R burst is routed at a time.
- The interconnect crossbar muxes consume the grant and select outputs.

---
 rtl/read_arbiter_pkg.sv | 10 +
 rtl/read_arbiter_fifo.sv | 50 +++++
 rtl/read_arbiter.sv | 123 ++++++++++++
 tb/tb_read_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_arbiter_pkg.sv
// read_arbiter_pkg: FSM encodings, default slave address span and a width helper
// shared by the read-path arbiter and its per-master order queues.
package read_arbiter_pkg;
   typedef enum logic {AR_IDLE, AR_ALLOW} ar_state_e;
   typedef enum logic {R_IDLE, R_BURST} r_state_e;
   localparam logic [31:0] SLICE_SIZE_DEFAULT = 32'h0001_0000;
   function automatic int clog2w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/read_arbiter_fifo.sv
// rd_order_fifo: per-master in-order queue of target slave indices; a push and a
// pop in the same cycle are both honoured, including a push while full.
module rd_order_fifo
   import read_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  write_en,
   input  logic                  read_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  empty,
   output logic                  full
);
   localparam int PW = clog2w(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   always_comb begin
      mem_d = mem_q;
      if (write_en) mem_d[wr_q] = data_in;
      wr_d  = write_en ? inc(wr_q) : wr_q;
      rd_d  = read_en ? inc(rd_q) : rd_q;
      cnt_d = cnt_q + CW'(write_en) - CW'(read_en);
   end
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   assign head  = mem_q[rd_q];
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));
endmodule

// File: rtl/read_arbiter.sv
// read_arbiter: round-robin AR arbitration with address decode, plus in-order
// R-burst routing replayed from per-master queues of target slaves.
module read_arbiter
   import read_arbiter_pkg::*;
#(
   parameter int          M                     = 2,
   parameter int          S                     = 2,
   parameter int          NUM_OUTSTANDING_TRANS = 2,
   parameter int          ADDR_WIDTH            = 32,
   parameter logic [31:0] SLICE_SIZE            = SLICE_SIZE_DEFAULT
) (
   input  logic                             clk,
   input  logic                             clr,
   input  logic [M-1:0]                     AR_valid_f,
   input  logic [M*ADDR_WIDTH-1:0]          AR_addr_f,
   output logic [M-1:0]                     AR_grant_f,
   output logic [M*clog2w(S)-1:0]           AR_sel_f,
   input  logic [S-1:0]                     R_valid_f,
   input  logic [S-1:0]                     R_last_f,
   input  logic [M-1:0]                     R_ready_f,
   output logic [S-1:0]                     R_grant_f,
   output logic [S*clog2w(M)-1:0]           R_sel_f,
   output logic [M-1:0]                     R_mgrant_f,
   output logic [M*clog2w(S)-1:0]           R_msel_f
);
   localparam int SW = clog2w(S);
   localparam int MW = clog2w(M);
   ar_state_e ar_state_q, ar_state_d;
   r_state_e  r_state_q, r_state_d;
   logic [MW-1:0] ar_ptr_q, ar_ptr_d, r_ptr_q, r_ptr_d;
   logic [SW-1:0] r_slave_q, r_slave_d;
   logic [SW-1:0] sel  [M];
   logic [SW-1:0] head [M];
   logic [M-1:0]  push, pop, empty, full;
   function automatic logic [MW-1:0] nxt(input logic [MW-1:0] p);
      return (p == MW'(M - 1)) ? '0 : p + 1'b1;
   endfunction
   always_comb begin
      for (int i = 0; i < M; i++)
         sel[i] = SW'((AR_addr_f[i*ADDR_WIDTH +: ADDR_WIDTH] / ADDR_WIDTH'(SLICE_SIZE)) % ADDR_WIDTH'(S));
   end
   // A full queue still accepts a push when the R side pops it this cycle.
   always_comb begin
      ar_state_d = ar_state_q;
      ar_ptr_d   = ar_ptr_q;
      push       = '0;
      AR_grant_f = '0;
      AR_sel_f   = '0;
      if (ar_state_q == AR_IDLE) begin
         if (AR_valid_f[ar_ptr_q] && (!full[ar_ptr_q] || pop[ar_ptr_q])) begin
            push[ar_ptr_q] = 1'b1;
            ar_state_d     = AR_ALLOW;
         end else begin
            ar_ptr_d = nxt(ar_ptr_q);
         end
      end else begin
         AR_grant_f[ar_ptr_q]            = 1'b1;
         AR_sel_f[ar_ptr_q*SW +: SW]     = sel[ar_ptr_q];
         if (!AR_valid_f[ar_ptr_q]) begin
            ar_state_d = AR_IDLE;
            ar_ptr_d   = nxt(ar_ptr_q);
         end
      end
   end
   always_comb begin
      r_state_d  = r_state_q;
      r_ptr_d    = r_ptr_q;
      r_slave_d  = r_slave_q;
      pop        = '0;
      R_grant_f  = '0;
      R_sel_f    = '0;
      R_mgrant_f = '0;
      R_msel_f   = '0;
      if (r_state_q == R_IDLE) begin
         if (!empty[r_ptr_q] && R_valid_f[head[r_ptr_q]] && R_ready_f[r_ptr_q]) begin
            pop[r_ptr_q] = 1'b1;
            r_slave_d    = head[r_ptr_q];
            r_state_d    = R_BURST;
         end else begin
            r_ptr_d = nxt(r_ptr_q);
         end
      end else begin
         R_grant_f[r_slave_q]          = 1'b1;
         R_sel_f[r_slave_q*MW +: MW]   = r_ptr_q;
         R_mgrant_f[r_ptr_q]           = 1'b1;
         R_msel_f[r_ptr_q*SW +: SW]    = r_slave_q;
         if (R_valid_f[r_slave_q] && R_ready_f[r_ptr_q] && R_last_f[r_slave_q]) begin
            r_state_d = R_IDLE;
            r_ptr_d   = nxt(r_ptr_q);
         end
      end
   end
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         ar_state_q <= AR_IDLE;
         r_state_q  <= R_IDLE;
         ar_ptr_q   <= '0;
         r_ptr_q    <= '0;
         r_slave_q  <= '0;
      end else begin
         ar_state_q <= ar_state_d;
         r_state_q  <= r_state_d;
         ar_ptr_q   <= ar_ptr_d;
         r_ptr_q    <= r_ptr_d;
         r_slave_q  <= r_slave_d;
      end
   end
   for (genvar g = 0; g < M; g++) begin : g_q
      rd_order_fifo #(
         .DATA_WIDTH(SW),
         .DEPTH     (NUM_OUTSTANDING_TRANS)
      ) u_fifo (
         .clk     (clk),
         .clr     (clr),
         .write_en(push[g]),
         .read_en (pop[g]),
         .data_in (sel[g]),
         .head    (head[g]),
         .empty   (empty[g]),
         .full    (full[g])
      );
   end
endmodule

// File: tb/tb_read_arbiter.sv
// tb_read_arbiter: directed table of read transactions plus hand-written
// sequences for round-robin, full queue, ordering, backpressure and reset.
module tb_read_arbiter;
   localparam int M  = 2;
   localparam int S  = 2;
   localparam int AW = 32;
   localparam int SW = $clog2(S);
   localparam int MW = $clog2(M);
   logic clk = 1'b0;
   logic clr = 1'b0;
   logic [M-1:0]    AR_valid_f;
   logic [M*AW-1:0] AR_addr_f;
   logic [M-1:0]    AR_grant_f;
   logic [M*SW-1:0] AR_sel_f;
   logic [S-1:0]    R_valid_f, R_last_f;
   logic [M-1:0]    R_ready_f;
   logic [S-1:0]    R_grant_f;
   logic [S*MW-1:0] R_sel_f;
   logic [M-1:0]    R_mgrant_f;
   logic [M*SW-1:0] R_msel_f;
   int n_cmp = 0;
   int n_err = 0;
   typedef struct {
      logic [31:0] addr;
      int          mst;
      int          sel;
      int          beats;
   } vec_t;
   vec_t vecs [6];
   read_arbiter #(
      .M(M), .S(S), .NUM_OUTSTANDING_TRANS(2), .ADDR_WIDTH(AW), .SLICE_SIZE(32'h0001_0000)
   ) dut (
      .clk(clk), .clr(clr),
      .AR_valid_f(AR_valid_f), .AR_addr_f(AR_addr_f), .AR_grant_f(AR_grant_f), .AR_sel_f(AR_sel_f),
      .R_valid_f(R_valid_f), .R_last_f(R_last_f), .R_ready_f(R_ready_f),
      .R_grant_f(R_grant_f), .R_sel_f(R_sel_f), .R_mgrant_f(R_mgrant_f), .R_msel_f(R_msel_f)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic clear_in;
      AR_valid_f = '0;
      AR_addr_f  = '0;
      R_valid_f  = '0;
      R_last_f   = '0;
      R_ready_f  = '0;
   endtask
   task automatic do_reset;
      clr = 1'b0;
      tick;
      tick;
      clr = 1'b1;
   endtask
   function automatic logic [63:0] all_out();
      return 64'({AR_grant_f, AR_sel_f, R_grant_f, R_sel_f, R_mgrant_f, R_msel_f});
   endfunction
   function automatic logic [63:0] r_exp(input int s, input int m);
      logic [S-1:0]    g  = '0;
      logic [S*MW-1:0] sl = '0;
      logic [M-1:0]    mg = '0;
      logic [M*SW-1:0] ms = '0;
      g[s] = 1'b1;
      sl[s*MW +: MW] = MW'(m);
      mg[m] = 1'b1;
      ms[m*SW +: SW] = SW'(s);
      return 64'({g, sl, mg, ms});
   endfunction
   task automatic issue_ar(input int m, input logic [31:0] addr, input int s);
      int w = 0;
      AR_addr_f[m*AW +: AW] = addr;
      AR_valid_f[m] = 1'b1;
      while (!AR_grant_f[m] && w < 8) begin
         tick;
         w++;
      end
      check("ar_grant", 64'(AR_grant_f), 64'(1) << m);
      check("ar_sel", 64'(AR_sel_f), 64'(s) << (m * SW));
      AR_valid_f[m] = 1'b0;
      tick;
      check("ar_release", 64'(AR_grant_f), 0);
   endtask
   task automatic r_burst(input int s, input int m, input int n, input int stall);
      int w = 0;
      R_valid_f[s] = 1'b1;
      R_ready_f[m] = 1'b1;
      R_last_f[s]  = 1'b0;
      while (!R_grant_f[s] && w < 8) begin
         tick;
         w++;
      end
      for (int k = 1; k <= n; k++) begin
         R_last_f[s] = (k == n);
         if (k == stall) begin
            R_ready_f[m] = 1'b0;
            repeat (3) begin
               tick;
               check("r_stall_hold", 64'({R_grant_f, R_sel_f, R_mgrant_f, R_msel_f}), r_exp(s, m));
            end
            R_ready_f[m] = 1'b1;
         end
         check("r_route", 64'({R_grant_f, R_sel_f, R_mgrant_f, R_msel_f}), r_exp(s, m));
         tick;
      end
      check("r_done", 64'({R_grant_f, R_sel_f, R_mgrant_f, R_msel_f}), 0);
      R_valid_f[s] = 1'b0;
      R_last_f[s]  = 1'b0;
      R_ready_f[m] = 1'b0;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int cnt;
      int exp_m;
      int w;
      vecs[0] = '{32'h0001_0004, 0, 1, 4};
      vecs[1] = '{32'h0000_0000, 1, 0, 1};
      vecs[2] = '{32'h0002_0000, 0, 0, 2};
      vecs[3] = '{32'h0003_FFFC, 1, 1, 3};
      vecs[4] = '{32'hFFFF_FFFF, 0, 1, 1};
      vecs[5] = '{32'h0000_FFFF, 1, 0, 2};
      clear_in;
      tick;
      check("reset_outputs", all_out(), 0);
      // Single read with exact latency: M0 valid is already up when reset releases.
      AR_addr_f[0 +: AW] = 32'h0001_0004;
      AR_valid_f[0] = 1'b1;
      clr = 1'b1;
      tick;
      check("latency_grant", 64'(AR_grant_f), 64'b01);
      check("latency_sel", 64'(AR_sel_f), 64'b01);
      AR_valid_f[0] = 1'b0;
      tick;
      r_burst(1, 0, 4, 0);
      check("single_idle", all_out(), 0);
      clear_in;
      do_reset;
      for (int i = 0; i < 6; i++) begin
         issue_ar(vecs[i].mst, vecs[i].addr, vecs[i].sel);
         r_burst(vecs[i].sel, vecs[i].mst, vecs[i].beats, 0);
      end
      // Round robin with both masters requesting continuously.
      clear_in;
      AR_addr_f = {32'h0001_0000, 32'h0000_0000};
      AR_valid_f = 2'b11;
      do_reset;
      exp_m = 0;
      for (int i = 0; i < 4; i++) begin
         w = 0;
         while (AR_grant_f == '0 && w < 8) begin
            tick;
            w++;
         end
         check("rr_grant", 64'(AR_grant_f), 64'(1) << exp_m);
         AR_valid_f[exp_m] = 1'b0;
         tick;
         AR_valid_f[exp_m] = 1'b1;
         exp_m ^= 1;
      end
      AR_valid_f = '0;
      tick;
      r_burst(0, 0, 1, 0);
      r_burst(0, 0, 1, 0);
      r_burst(1, 1, 2, 0);
      r_burst(1, 1, 1, 0);
      // Full queue blocks the third AR until an R burst drains one entry.
      clear_in;
      do_reset;
      issue_ar(0, 32'h0001_0000, 1);
      issue_ar(0, 32'h0001_0000, 1);
      AR_addr_f[0 +: AW] = 32'h0001_0000;
      AR_valid_f[0] = 1'b1;
      cnt = 0;
      repeat (10) begin
         tick;
         if (AR_grant_f[0]) cnt++;
      end
      check("full_blocked", 64'(cnt), 0);
      r_burst(1, 0, 2, 0);
      w = 0;
      while (!AR_grant_f[0] && w < 8) begin
         tick;
         w++;
      end
      check("full_regrant", 64'(AR_grant_f), 64'b01);
      AR_valid_f[0] = 1'b0;
      tick;
      r_burst(1, 0, 1, 0);
      r_burst(1, 0, 1, 0);
      // In-order return: slave0 ready early must wait behind slave1.
      clear_in;
      do_reset;
      issue_ar(0, 32'h0001_0000, 1);
      issue_ar(0, 32'h0000_0000, 0);
      R_valid_f[0] = 1'b1;
      R_last_f[0]  = 1'b1;
      R_ready_f[0] = 1'b1;
      cnt = 0;
      repeat (6) begin
         tick;
         if (R_grant_f != '0) cnt++;
      end
      check("order_hold", 64'(cnt), 0);
      r_burst(1, 0, 2, 0);
      r_burst(0, 0, 1, 0);
      // Backpressure in the middle of a 4-beat burst.
      clear_in;
      do_reset;
      issue_ar(0, 32'h0001_0000, 1);
      r_burst(1, 0, 4, 2);
      // Reset in the middle of a burst, with a second read still queued.
      clear_in;
      do_reset;
      issue_ar(0, 32'h0001_0000, 1);
      issue_ar(0, 32'h0000_0000, 0);
      R_valid_f[1] = 1'b1;
      R_ready_f[0] = 1'b1;
      w = 0;
      while (!R_grant_f[1] && w < 8) begin
         tick;
         w++;
      end
      check("rb_burst_open", 64'(R_grant_f), 64'b10);
      tick;
      clr = 1'b0;
      #1;
      check("rb_async_zero", all_out(), 0);
      R_valid_f  = 2'b01;
      R_last_f   = 2'b01;
      R_ready_f  = 2'b11;
      AR_addr_f  = {32'h0001_0000, 32'h0000_0000};
      AR_valid_f = 2'b10;
      tick;
      check("rb_held_zero", all_out(), 0);
      clr = 1'b1;
      tick;
      check("rb_ptr0_skip", 64'(AR_grant_f), 0);
      tick;
      check("rb_m1_grant", 64'(AR_grant_f), 64'b10);
      check("rb_m1_sel", 64'(AR_sel_f), 64'b10);
      cnt = 0;
      repeat (5) begin
         tick;
         if (R_grant_f != '0) cnt++;
      end
      check("rb_queues_empty", 64'(cnt), 0);
      clear_in;
      tick;
      tick;
      check("final_idle", all_out(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
